// File: rtl/chacha_skid_pipeline.sv
// Valid/ready register slice with registered forward and backward paths.
// Each stage has a main and a skid register, so a chain sustains one beat per cycle.
module chacha_skid_pipeline #(
  parameter int unsigned DATA_BUS_W  = 8,
  parameter int unsigned NB_PIPELINE = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_BUS_W-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_BUS_W-1:0] o_data
);

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  if (NB_PIPELINE == 0) begin : g_passthrough
    logic unused_ctrl;
    assign unused_ctrl = aclk ^ aresetn ^ srst;

    assign o_valid = i_valid;
    assign o_data  = i_data;
    assign i_ready = o_ready;
  end else begin : g_stages
    // Index k is the boundary feeding stage k; index NB_PIPELINE is the output side.
    logic [NB_PIPELINE:0]                 vld;
    logic [NB_PIPELINE:0]                 rdy;
    logic [NB_PIPELINE:0][DATA_BUS_W-1:0] dat;

    assign vld[0]           = i_valid;
    assign dat[0]           = i_data;
    assign rdy[NB_PIPELINE] = o_ready;
    assign i_ready          = rdy[0];
    assign o_valid          = vld[NB_PIPELINE];
    assign o_data           = dat[NB_PIPELINE];

    for (genvar g = 0; g < NB_PIPELINE; g++) begin : g_stage
      state_e                state_q, state_d;
      logic [DATA_BUS_W-1:0] main_q, main_d;
      logic [DATA_BUS_W-1:0] skid_q, skid_d;
      logic                  vld_q;
      logic                  rdy_q;
      logic                  in_xfer;
      logic                  out_xfer;

      assign in_xfer  = vld[g] & rdy_q;
      assign out_xfer = vld_q & rdy[g+1];

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          StEmpty: begin
            if (in_xfer) begin
              main_d  = dat[g];
              state_d = StBusy;
            end
          end
          StBusy: begin
            if (in_xfer && out_xfer) begin
              main_d = dat[g];
            end else if (in_xfer) begin
              skid_d  = dat[g];
              state_d = StFull;
            end else if (out_xfer) begin
              state_d = StEmpty;
            end
          end
          StFull: begin
            if (out_xfer) begin
              main_d  = skid_q;
              state_d = StBusy;
            end
          end
          default: state_d = StEmpty;
        endcase
      end

      // Valid and ready are flopped from next state so both directions leave on flop outputs.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          state_q <= StEmpty;
          main_q  <= '0;
          skid_q  <= '0;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b0;
        end else if (srst) begin
          state_q <= StEmpty;
          main_q  <= '0;
          skid_q  <= '0;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          vld_q   <= (state_d != StEmpty);
          rdy_q   <= (state_d != StFull);
        end
      end

      assign vld[g+1] = vld_q;
      assign dat[g+1] = main_q;
      assign rdy[g]   = rdy_q;
    end
  end

endmodule
